// File: rtl/price_window_feeder_if.sv
// Handshake bundle between the price ingest stream, the window feeder and the
// moving-average engine. The feeder uses the slave view; the environment uses master.
interface price_window_feeder_if #(
  parameter int DW = 16
) ();
  logic          in_valid;
  logic [DW-1:0] in_price;
  logic          in_ready;
  logic          ma_start;
  logic [DW-1:0] ma_new_price;
  logic [DW-1:0] ma_oldest_price;
  logic          ma_done;

  modport slave (
    input  in_valid, in_price, ma_done,
    output in_ready, ma_start, ma_new_price, ma_oldest_price
  );

  modport master (
    output in_valid, in_price, ma_done,
    input  in_ready, ma_start, ma_new_price, ma_oldest_price
  );
endinterface

// File: rtl/price_window_feeder.sv
// Rolling-window feeder: keeps the last WINDOW prices and hands the averager each
// (entering, leaving) pair with a start/done handshake guarded by a timeout.
module price_window_feeder #(
  parameter int WINDOW  = 20,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  price_window_feeder_if.slave         bus,
  output logic [$clog2(WINDOW+1)-1:0]  fill_count,
  output logic                         window_full,
  output logic                         busy,
  output logic                         timeout_err
);
  localparam int PW = $clog2(WINDOW);
  localparam int CW = $clog2(WINDOW + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [PW-1:0] LAST_PTR = PW'(WINDOW - 1);
  localparam logic [CW-1:0] FILL_MAX = CW'(WINDOW);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [TW-1:0] to_cnt;
  logic [DW-1:0] mem [WINDOW];
  logic          accept;

  assign accept       = (state == IDLE) && bus.in_valid;
  assign bus.in_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign window_full  = (fill_count == FILL_MAX);

  // NOTE: the sample store has no reset; fill_count decides which entries are
  // meaningful, so leaving it unreset keeps it a plain RAM without reset muxes.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.in_price;
  end

  // NOTE: all state updates use non-blocking assignments, so the mem read below
  // sees the pre-write entry at wr_ptr (read-before-write) within the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      wr_ptr              <= '0;
      fill_count          <= '0;
      to_cnt              <= '0;
      timeout_err         <= 1'b0;
      bus.ma_start        <= 1'b0;
      bus.ma_new_price    <= '0;
      bus.ma_oldest_price <= '0;
    end else begin
      bus.ma_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.ma_oldest_price <= window_full ? mem[wr_ptr] : '0;
            bus.ma_new_price    <= bus.in_price;
            wr_ptr              <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            if (!window_full) fill_count <= fill_count + CW'(1);
            bus.ma_start        <= 1'b1;
            state               <= ISSUE;
          end
        end
        ISSUE: begin
          to_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.ma_done) begin
            to_cnt <= '0;
            state  <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            // Abandon the transaction; the sample already sits in the window.
            timeout_err <= 1'b1;
            to_cnt      <= '0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/price_window_feeder.md
Name: price_window_feeder

Overview:
- Producer side of the moving-average handshake.
- Buffers the last WINDOW accepted price samples in a circular buffer.
- For every new sample, presents the new price and the price leaving the window, pulses start, and waits for done.
- Sits between the price ingest stream and moving_average_fsm, so the averager's running sum stays exact across window wrap-around.

Parameters:
- WINDOW, 20, number of samples in the rolling window (>=2).
- DW, 16, price sample width.
- TIMEOUT, 64, maximum cycles to wait for ma_done before aborting a transaction (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  incoming price sample valid.
- in_price  in  DW  incoming price sample.
- in_ready  out  1  feeder can accept a sample this cycle.
- ma_start  out  1  one-cycle start pulse to the averager.
- ma_new_price  out  DW  price entering the window.
- ma_oldest_price  out  DW  price leaving the window (0 while filling).
- ma_done  in  1  averager completion pulse.
- fill_count  out  clog2(WINDOW+1)  number of valid samples in the buffer, saturates at WINDOW.
- window_full  out  1  fill_count == WINDOW.
- busy  out  1  transaction in flight (state != IDLE).
- timeout_err  out  1  sticky: a transaction timed out.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - wr_ptr, fill_count, window_full, busy, timeout_err, ma_start, ma_new_price, ma_oldest_price and the timeout counter all go to 0.
  - in_ready = 1, since in_ready is decoded from state == IDLE.
  - Buffer RAM is not reset; fill_count gating guarantees stale entries are never used.
- State IDLE:
  - in_ready = 1.
  - On in_valid, the sample is accepted at that clock edge (T).
  - ma_oldest_price <= (window_full ? buf[wr_ptr] : 0).
  - ma_new_price <= in_price.
  - buf[wr_ptr] <= in_price. The read uses the pre-write value (read-before-write).
  - wr_ptr <= (wr_ptr == WINDOW-1) ? 0 : wr_ptr+1.
  - fill_count increments, saturating at WINDOW; window_full is updated in the same edge.
  - Next state is ISSUE.
- State ISSUE:
  - ma_start = 1 for exactly this cycle (T+1).
  - Timeout counter cleared; next state is WAIT_DONE.
- State WAIT_DONE:
  - ma_start = 0 and in_ready = 0.
  - The timeout counter increments each cycle.
  - On ma_done: next state is IDLE and the counter clears.
  - Else if the counter reaches TIMEOUT-1: timeout_err <= 1 (sticky until reset) and next state is IDLE. The buffer write and pointer advance for that sample stand.
- ma_done is sampled only in WAIT_DONE. Pulses in IDLE or ISSUE are ignored.
- ma_new_price and ma_oldest_price stay stable from T+1 until the next accepted sample; they change only on acceptance.
- Minimum sample spacing:
  - accept → ISSUE → WAIT_DONE, with ma_done no earlier than the cycle after ma_start → IDLE.
  - Against moving_average_fsm, ma_done arrives 2 cycles after ma_start, giving 4 cycles per sample.
- Simultaneous events: in_valid while not in IDLE is held off by in_ready = 0; the sample is neither dropped nor latched.
- Wrap-around: after the WINDOW-th sample, window_full = 1. Sample N+WINDOW reports sample N as oldest.
- Reset mid-transaction aborts immediately: no further ma_start, buffer treated as empty.

Test Plan:
- Reset, then samples 100, 200, 300, with the averager replying done 2 cycles after each start → 3 single-cycle ma_start pulses; (new, oldest) = (100,0), (200,0), (300,0); fill_count 1, 2, 3; window_full = 0.
- Samples 1..20, then 21 and 22 → window_full rises on the edge accepting sample 20; sample 21 gives oldest = 1, sample 22 gives oldest = 2; fill_count stays at 20.
- 45 samples, value k*10 for k = 1..45 → sample 41 gives oldest = 210; sample 45 gives oldest = 250; wr_ptr wraps twice with no glitch on ma_start.
- in_valid held high with price 500 while ma_done is delayed 5 cycles:
  - in_ready stays 0 and no second ma_start is issued.
  - Outputs stay stable through the wait.
  - 500 is accepted the cycle after the return to IDLE.
- TIMEOUT=8, ma_done never asserted → timeout_err = 1 exactly 8 cycles after entry to WAIT_DONE; the next sample is accepted, with oldest consistent with the advanced pointer.
- rst_n pulsed low during WAIT_DONE after 20 samples → outputs return to 0 asynchronously; the next sample 77 gives (77, 0) and fill_count = 1.
